ir_command_scheduler: RTL and testbench

- Upstream stage of the IR transmitter state machine.
- Samples four raw direction buttons and resolves them into a legal 4-bit drive command.
- Emits that command with a single-cycle `SEND_PACKET` strobe at a fixed packet rate.
- Holds `COMMAND` stable between strobes, so the transmitter always encodes a coherent packet.

---
 rtl/ir_command_scheduler.sv | 179 +++++++++++++++++
 tb/tb_ir_command_scheduler.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_command_scheduler.sv
// IR command scheduler: conditions four direction buttons, resolves axis conflicts and
// strobes a stable 4-bit COMMAND at a fixed packet rate. Debounce filter enabled by IR_CMD_DEBOUNCE_EN.
module ir_command_scheduler #(
  parameter int CLK_FREQ_HZ     = 50_000_000,
  parameter int PACKET_RATE_HZ  = 10,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ENABLE,
  input  logic       BTN_RIGHT,
  input  logic       BTN_LEFT,
  input  logic       BTN_BACK,
  input  logic       BTN_FWD,
  output logic [3:0] COMMAND,
  output logic       SEND_PACKET,
  output logic [7:0] PACKET_COUNT
);

  localparam int PERIOD = CLK_FREQ_HZ / PACKET_RATE_HZ;
  localparam int PCNT_W = $clog2(PERIOD);
  localparam logic [PCNT_W-1:0] LATCH_AT = PCNT_W'(PERIOD - 3);

  if (PERIOD < 4) begin : g_period_check
    $error("ir_command_scheduler: CLK_FREQ_HZ/PACKET_RATE_HZ must be at least 4");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_debounce_check
    $error("ir_command_scheduler: DEBOUNCE_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_WAIT     = 2'd1,
    ST_LATCH    = 2'd2,
    ST_FIRE     = 2'd3
  } state_t;

  // Button vector packed in COMMAND bit order: {fwd, back, left, right}.
  logic [3:0] btn_raw;
  logic [3:0] sync1_q, sync1_d;
  logic [3:0] sync2_q, sync2_d;
  logic [3:0] s_level;
  logic [3:0] cmd_next;

  state_t            state_q, state_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic [3:0]        command_q, command_d;
  logic [7:0]        pkt_cnt_q, pkt_cnt_d;

  assign btn_raw = {BTN_FWD, BTN_BACK, BTN_LEFT, BTN_RIGHT};

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

`ifdef IR_CMD_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  for (genvar gi = 0; gi < 4; gi++) begin : g_debounce
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            stable_q, stable_d;

    // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
      db_cnt_d = db_cnt_q;
      stable_d = stable_q;
      if (sync2_q[gi] == stable_q) begin
        db_cnt_d = '0;
      end else if (32'(db_cnt_q) + 32'd1 >= 32'(DEBOUNCE_CYCLES)) begin
        stable_d = sync2_q[gi];
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end

    always_ff @(posedge CLK) begin
      if (!RESET) begin
        db_cnt_q <= '0;
        stable_q <= 1'b0;
      end else begin
        db_cnt_q <= db_cnt_d;
        stable_q <= stable_d;
      end
    end

    assign s_level[gi] = stable_q;
  end
`else
  assign s_level = sync2_q;
`endif

  // Opposing buttons on one axis cancel each other; the other axis is untouched.
  always_comb begin
    cmd_next[0] = s_level[0] & ~s_level[1];
    cmd_next[1] = s_level[1] & ~s_level[0];
    cmd_next[2] = s_level[2] & ~s_level[3];
    cmd_next[3] = s_level[3] & ~s_level[2];
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= ST_DISABLED;
    end else begin
      state_q <= state_d;
    end
  end

  // LATCH and FIRE always run to completion so a started packet is never cut short.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_DISABLED: if (ENABLE) state_d = ST_LATCH;
      ST_WAIT: begin
        if (!ENABLE) begin
          state_d = ST_DISABLED;
        end else if (pcnt_q == LATCH_AT) begin
          state_d = ST_LATCH;
        end
      end
      ST_LATCH: state_d = ST_FIRE;
      ST_FIRE:  state_d = ENABLE ? ST_WAIT : ST_DISABLED;
      default:  state_d = ST_DISABLED;
    endcase
  end

  always_comb begin
    SEND_PACKET = 1'b0;
    if (state_q == ST_FIRE) begin
      SEND_PACKET = 1'b1;
    end
  end

  // Counter restarts on FIRE, so FIRE-to-FIRE spans WAIT (PERIOD-2) + LATCH + FIRE.
  always_comb begin
    pcnt_d    = pcnt_q;
    command_d = command_q;
    pkt_cnt_d = pkt_cnt_q;
    if (state_d == ST_DISABLED || state_q == ST_FIRE) begin
      pcnt_d = '0;
    end else if (state_q == ST_WAIT) begin
      pcnt_d = pcnt_q + 1'b1;
    end
    if (state_q == ST_LATCH) begin
      command_d = cmd_next;
    end
    // The count is visible already during the strobe cycle that it numbers.
    if (state_d == ST_FIRE) begin
      pkt_cnt_d = pkt_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      pcnt_q    <= '0;
      command_q <= '0;
      pkt_cnt_q <= '0;
    end else begin
      pcnt_q    <= pcnt_d;
      command_q <= command_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign COMMAND      = command_q;
  assign PACKET_COUNT = pkt_cnt_q;

endmodule

// File: tb/tb_ir_command_scheduler.sv
// Directed self-checking bench for ir_command_scheduler (PERIOD=100, DEBOUNCE_CYCLES=4).
module tb_ir_command_scheduler;

  localparam int PERIOD = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       btn_right = 1'b0;
  logic       btn_left = 1'b0;
  logic       btn_back = 1'b0;
  logic       btn_fwd = 1'b0;
  logic [3:0] command;
  logic       send_packet;
  logic [7:0] packet_count;

  int n_compared = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  ir_command_scheduler #(
    .CLK_FREQ_HZ    (1000),
    .PACKET_RATE_HZ (10),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .CLK         (clk),
    .RESET       (rst_n),
    .ENABLE      (enable),
    .BTN_RIGHT   (btn_right),
    .BTN_LEFT    (btn_left),
    .BTN_BACK    (btn_back),
    .BTN_FWD     (btn_fwd),
    .COMMAND     (command),
    .SEND_PACKET (send_packet),
    .PACKET_COUNT(packet_count)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic set_btns(input logic [3:0] b);
    {btn_fwd, btn_back, btn_left, btn_right} = b;
  endtask

  // Advances until SEND_PACKET is seen; ticks = cycles taken.
  task automatic wait_strobe(input int max_ticks, output int ticks);
    ticks = 0;
    @(negedge clk);
    ticks++;
    while (send_packet !== 1'b1 && ticks < max_ticks) begin
      @(negedge clk);
      ticks++;
    end
    n_compared++;
    if (send_packet !== 1'b1) begin
      n_mismatched++;
      $display("FAIL strobe_timeout: no SEND_PACKET within %0d cycles, required a strobe", max_ticks);
    end
  endtask

  task automatic test_reset();
    enable = 1'b1;
    set_btns(4'b1111);
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      n_compared += 3;
      if (command !== 4'b0000) begin
        n_mismatched++;
        $display("FAIL reset_cmd: got %b required 0000", command);
      end
      if (send_packet !== 1'b0) begin
        n_mismatched++;
        $display("FAIL reset_send: got %b required 0", send_packet);
      end
      if (packet_count !== 8'd0) begin
        n_mismatched++;
        $display("FAIL reset_count: got %0d required 0", packet_count);
      end
    end
    rst_n = 1'b1;
    tick(1);
    n_compared++;
    if (send_packet !== 1'b0) begin
      n_mismatched++;
      $display("FAIL reset_release_early: got %b required 0", send_packet);
    end
    tick(1);
    n_compared += 3;
    if (send_packet !== 1'b1) begin
      n_mismatched++;
      $display("FAIL reset_first_strobe: got %b required 1", send_packet);
    end
    // Buttons have not crossed the synchronizer yet when the first LATCH samples them.
    if (command !== 4'b0000) begin
      n_mismatched++;
      $display("FAIL reset_first_cmd: got %b required 0000", command);
    end
    if (packet_count !== 8'd1) begin
      n_mismatched++;
      $display("FAIL reset_first_count: got %0d required 1", packet_count);
    end
    $display("test_reset done");
  endtask

  task automatic test_periodic();
    int gap;
    set_btns(4'b1000);
    enable = 1'b0;
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(20);
    n_compared += 2;
    if (send_packet !== 1'b0) begin
      n_mismatched++;
      $display("FAIL periodic_disabled_send: got %b required 0", send_packet);
    end
    if (command !== 4'b0000) begin
      n_mismatched++;
      $display("FAIL periodic_disabled_hold: got %b required 0000", command);
    end
    enable = 1'b1;
    tick(1);
    n_compared++;
    if (send_packet !== 1'b0) begin
      n_mismatched++;
      $display("FAIL periodic_enable_early: got %b required 0", send_packet);
    end
    tick(1);
    n_compared += 3;
    if (send_packet !== 1'b1) begin
      n_mismatched++;
      $display("FAIL periodic_enable_strobe: got %b required 1", send_packet);
    end
    if (command !== 4'b1000) begin
      n_mismatched++;
      $display("FAIL periodic_cmd1: got %b required 1000", command);
    end
    if (packet_count !== 8'd1) begin
      n_mismatched++;
      $display("FAIL periodic_count1: got %0d required 1", packet_count);
    end
    for (int k = 2; k <= 3; k++) begin
      wait_strobe(PERIOD + 5, gap);
      n_compared += 3;
      if (gap !== PERIOD) begin
        n_mismatched++;
        $display("FAIL periodic_gap: got %0d cycles required %0d", gap, PERIOD);
      end
      if (command !== 4'b1000) begin
        n_mismatched++;
        $display("FAIL periodic_cmd: got %b required 1000", command);
      end
      if (packet_count !== 8'(k)) begin
        n_mismatched++;
        $display("FAIL periodic_count: got %0d required %0d", packet_count, k);
      end
      $display("periodic strobe %0d gap=%0d cmd=%b count=%0d", k, gap, command, packet_count);
    end
  endtask

  // Starts and ends on a strobe cycle, so each new button pattern has a full period to settle.
  task automatic test_conflict();
    logic [3:0] btns [6] = '{4'b1011, 4'b1111, 4'b0110, 4'b1101, 4'b1010, 4'b0101};
    logic [3:0] want [6] = '{4'b1000, 4'b0000, 4'b0110, 4'b0001, 4'b1010, 4'b0101};
    int gap;
    for (int i = 0; i < 6; i++) begin
      set_btns(btns[i]);
      wait_strobe(PERIOD + 5, gap);
      n_compared++;
      if (command !== want[i]) begin
        n_mismatched++;
        $display("FAIL conflict_%0d: buttons %b got %b required %b", i, btns[i], command, want[i]);
      end
      $display("conflict buttons=%b cmd=%b", btns[i], command);
    end
  endtask

  task automatic test_debounce();
    int gap;
    int glitch_at;
`ifdef IR_CMD_DEBOUNCE_EN
    glitch_at = 96;
`else
    glitch_at = 10;
`endif
    set_btns(4'b0000);
    wait_strobe(PERIOD + 5, gap);
    n_compared++;
    if (command !== 4'b0000) begin
      n_mismatched++;
      $display("FAIL debounce_idle: got %b required 0000", command);
    end
    tick(glitch_at);
    btn_right = 1'b1;
    tick(3);
    btn_right = 1'b0;
    wait_strobe(PERIOD + 5, gap);
    n_compared += 2;
    if (command !== 4'b0000) begin
      n_mismatched++;
      $display("FAIL debounce_glitch: got %b required 0000", command);
    end
    if (glitch_at + 3 + gap !== PERIOD) begin
      n_mismatched++;
      $display("FAIL debounce_gap: got %0d cycles required %0d", glitch_at + 3 + gap, PERIOD);
    end
    $display("debounce glitch cmd=%b", command);
    tick(88);
    btn_right = 1'b1;
    tick(10);
    btn_right = 1'b0;
    wait_strobe(PERIOD + 5, gap);
    n_compared++;
    if (command !== 4'b0001) begin
      n_mismatched++;
      $display("FAIL debounce_held: got %b required 0001", command);
    end
    $display("debounce held cmd=%b", command);
  endtask

  task automatic test_disable_mid_packet();
    logic [7:0] c0;
    int n_strobes;
    int n_cmd_changes;
    int gap;
    c0 = packet_count;
    set_btns(4'b0100);
    tick(PERIOD - 1);
    enable = 1'b0;
    tick(1);
    n_compared += 3;
    if (send_packet !== 1'b1) begin
      n_mismatched++;
      $display("FAIL disable_strobe_completes: got %b required 1", send_packet);
    end
    if (command !== 4'b0100) begin
      n_mismatched++;
      $display("FAIL disable_cmd: got %b required 0100", command);
    end
    if (packet_count !== c0 + 8'd1) begin
      n_mismatched++;
      $display("FAIL disable_count: got %0d required %0d", packet_count, c0 + 8'd1);
    end
    set_btns(4'b1000);
    n_strobes = 0;
    n_cmd_changes = 0;
    for (int i = 0; i < 300; i++) begin
      tick(1);
      if (send_packet !== 1'b0) n_strobes++;
      if (command !== 4'b0100) n_cmd_changes++;
    end
    n_compared += 3;
    if (n_strobes !== 0) begin
      n_mismatched++;
      $display("FAIL disable_no_strobe: got %0d strobes required 0", n_strobes);
    end
    if (n_cmd_changes !== 0) begin
      n_mismatched++;
      $display("FAIL disable_cmd_hold: got %0d changed cycles required 0", n_cmd_changes);
    end
    if (packet_count !== c0 + 8'd1) begin
      n_mismatched++;
      $display("FAIL disable_count_hold: got %0d required %0d", packet_count, c0 + 8'd1);
    end
    enable = 1'b1;
    tick(1);
    n_compared++;
    if (send_packet !== 1'b0) begin
      n_mismatched++;
      $display("FAIL reenable_early: got %b required 0", send_packet);
    end
    tick(1);
    n_compared += 3;
    if (send_packet !== 1'b1) begin
      n_mismatched++;
      $display("FAIL reenable_strobe: got %b required 1", send_packet);
    end
    if (command !== 4'b1000) begin
      n_mismatched++;
      $display("FAIL reenable_cmd: got %b required 1000", command);
    end
    if (packet_count !== c0 + 8'd2) begin
      n_mismatched++;
      $display("FAIL reenable_count: got %0d required %0d", packet_count, c0 + 8'd2);
    end
    wait_strobe(PERIOD + 5, gap);
    n_compared++;
    if (gap !== PERIOD) begin
      n_mismatched++;
      $display("FAIL reenable_gap: got %0d cycles required %0d", gap, PERIOD);
    end
    $display("disable/reenable cmd=%b count=%0d", command, packet_count);
  endtask

  // Reset applied while the FSM is in LATCH lands on the FIRE edge and must kill the strobe.
  task automatic test_reset_in_fire();
    tick(PERIOD - 1);
    rst_n = 1'b0;
    tick(1);
    n_compared += 3;
    if (send_packet !== 1'b0) begin
      n_mismatched++;
      $display("FAIL fire_reset_send: got %b required 0", send_packet);
    end
    if (packet_count !== 8'd0) begin
      n_mismatched++;
      $display("FAIL fire_reset_count: got %0d required 0", packet_count);
    end
    if (command !== 4'b0000) begin
      n_mismatched++;
      $display("FAIL fire_reset_cmd: got %b required 0000", command);
    end
    rst_n = 1'b1;
    $display("reset during fire send=%b count=%0d", send_packet, packet_count);
  endtask

  task automatic test_wrap();
    int gap;
    enable = 1'b1;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    n_compared += 2;
    if (send_packet !== 1'b1) begin
      n_mismatched++;
      $display("FAIL wrap_first_strobe: got %b required 1", send_packet);
    end
    if (packet_count !== 8'd1) begin
      n_mismatched++;
      $display("FAIL wrap_first_count: got %0d required 1", packet_count);
    end
    for (int k = 2; k <= 256; k++) begin
      wait_strobe(PERIOD + 5, gap);
      n_compared += 2;
      if (packet_count !== 8'(k)) begin
        n_mismatched++;
        $display("FAIL wrap_count: strobe %0d got %0d required %0d", k, packet_count, 8'(k));
      end
      if (gap !== PERIOD) begin
        n_mismatched++;
        $display("FAIL wrap_gap: strobe %0d got %0d cycles required %0d", k, gap, PERIOD);
      end
    end
    $display("wrap after 256 strobes count=%0d", packet_count);
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_conflict();
    test_debounce();
    test_disable_mid_packet();
    test_reset_in_fire();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
